axis_gpio_sampler: RTL and testbench
====================================

# axis_gpio_sampler

Capture sequencer placed between the GPIO input reader's always-valid sample stream and a DMA/FIFO writer. It arms on command and triggers on a masked rising edge of the GPIO word or on a software pulse. It then emits a fixed-length, decimated burst of GPIO words as an AXI4-Stream packet with `tlast` on the final beat. Status outputs expose the state, the sample count and a sticky overflow flag.

## Interface
- `AXIS_TDATA_WIDTH`, 32, width of the GPIO word and of both stream data buses.
- `CNTR_WIDTH`, 32, width of the decimation and sample counters.

- `aclk`  in  1  single clock; all logic is clocked on its rising edge.
- `areset`  in  1  reset: synchronous, active-high.
- `cfg_mask`  in  AXIS_TDATA_WIDTH  bits that participate in edge triggering.
- `cfg_decim`  in  CNTR_WIDTH  emit one sample every `cfg_decim+1` accepted input beats.
- `cfg_count`  in  CNTR_WIDTH  samples per burst.
- `arm`  in  1  single-cycle pulse; arms the trigger.
- `trg_soft`  in  1  single-cycle pulse; software trigger.
- `s_axis_tdata`  in  AXIS_TDATA_WIDTH  GPIO word.
- `s_axis_tvalid`  in  1  input valid; normally held at 1.
- `s_axis_tready`  out  1  input accepted.
- `m_axis_tdata`  out  AXIS_TDATA_WIDTH  sampled word.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  final sample of the burst.
- `sts_state`  out  2  0 = IDLE, 1 = ARMED, 2 = CAPTURE, 3 = DONE.
- `sts_count`  out  CNTR_WIDTH  samples loaded in the current or last burst.
- `sts_overflow`  out  1  sticky; set when an input beat is refused.

## Operation
- **Accepted beat:** `s_axis_tvalid && s_axis_tready`.
- **Edge history register:**
  - `prev` updates on every accepted beat.
  - A `prev_ok` flag is cleared by reset and set on the first accepted beat.
  - Edge triggering is disabled while `prev_ok` is 0.
- **Edge condition:** `|(cfg_mask & s_axis_tdata & ~prev) && prev_ok`.
- **Soft trigger:**
  - `trg_soft` in ARMED sets a pending flag.
  - The trigger fires on the next accepted beat, including a beat in the same cycle as the pulse.
  - The pending flag clears when the burst starts.
- **State machine:**
  - IDLE:
    - On `arm` with `cfg_count != 0`: latch `cfg_decim` and `cfg_count`, clear `sts_count`, go to ARMED.
    - `arm` with `cfg_count == 0` is ignored.
    - `arm` in any other state is ignored.
  - ARMED:
    - On an accepted beat with an edge condition or a pending soft trigger, load that beat into the output register as sample 1.
    - Set `sts_count` to 1 and load the decimation counter with `cfg_decim`.
    - Go to DONE if the latched count is 1; otherwise go to CAPTURE.
  - CAPTURE:
    - Each accepted beat with decimation counter != 0 decrements the counter.
    - An accepted beat with counter == 0 loads the output register, increments `sts_count` and reloads the counter.
    - When `sts_count` reaches the latched count: assert `m_axis_tlast` with that beat and go to DONE.
  - DONE: stay until the final beat is accepted downstream, then go to IDLE.
- **Output register:**
  - Single stage.
  - `m_axis_tvalid` sets on load and clears on `m_axis_tready` unless it is reloaded in the same cycle.
  - The output register is always empty in IDLE and ARMED.
- **Backpressure:**
  - `s_axis_tready` = 0 only in CAPTURE when the decimation counter == 0 and `m_axis_tvalid && !m_axis_tready`.
  - It is 1 in every other case, including IDLE, ARMED and DONE.
  - A refused beat (`s_axis_tvalid && !s_axis_tready`) sets `sts_overflow`.
  - `sts_overflow` clears only on reset or on an accepted `arm`.
  - A refused beat is not counted.
- **Counters:** unsigned, `CNTR_WIDTH` bits, no wrap within a burst since `cfg_count` is bounded by the width.
- **Config timing:** config changes after `arm` have no effect until the next `arm`.

## Timing
- **Reset values:**
  - `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0.
  - `s_axis_tready` = 1.
  - `sts_state` = IDLE, `sts_count` = 0, `sts_overflow` = 0.
  - `prev_ok` = 0 and the pending soft trigger is cleared.
- **Reset mid-burst:**
  - Abort at the next edge; `m_axis_tvalid` drops without a handshake.
  - No partial `tlast` is emitted.
- **Latency:** an input beat accepted in cycle t appears on `m_axis_tdata` with `tvalid` in cycle t+1.
- **Arm timing:** `arm` in cycle t gives ARMED in t+1; a trigger beat in t+1 is valid.
- **Decimation spacing:**
  - With steady input and ready output, samples are spaced exactly `cfg_decim+1` cycles apart.
  - With `cfg_decim = 0`, every beat is a sample.
- **Same-cycle output:** a load and a downstream accept in the same cycle keep `tvalid` = 1 with the new data.

## Structure
- Shared package holds the state encoding constants (IDLE/ARMED/CAPTURE/DONE) for reuse by the register-map logic.
- One sub-module, `axis_gpio_edge_detect`: holds `prev`, `prev_ok` and the masked rising-edge output.
- The FSM, counters and output register live in the top level.

## Test plan
- `arm`, mask 0x1, `cfg_decim` = 0, `cfg_count` = 4; input toggles bit0 0→1 at beat 10 -> 4 beats with data of beats 10–13, `tlast` on the 4th, state returns to IDLE.
- `cfg_decim` = 2, `cfg_count` = 3, `trg_soft` -> samples at trigger beat n, n+3 and n+6.
- `m_axis_tready` held low for 5 cycles mid-burst with `cfg_decim` = 0 -> `s_axis_tready` low, `sts_overflow` = 1, no sample lost or duplicated, `tlast` still on beat `cfg_count`.
- Bit0 high in the first beat after reset while armed -> no trigger until a real 0→1 edge.
- `arm` with `cfg_count` = 0, and `arm` during CAPTURE -> both ignored, state unchanged.
- `areset` during CAPTURE -> next cycle: `m_axis_tvalid` = 0, state IDLE, `sts_count` = 0, `sts_overflow` = 0.

Source files
------------

// File: rtl/axis_gpio_sampler_pkg.sv
// -----------------------------------------------------------------------------
// axis_gpio_sampler_pkg
// Shared definitions for the GPIO capture sequencer: default bus widths,
// the status state encoding (also consumed by register-map logic) and a
// helper that converts the FSM state to its 2-bit status code.
// -----------------------------------------------------------------------------
package axis_gpio_sampler_pkg;

  localparam int unsigned AXIS_TDATA_WIDTH_DEF = 32;
  localparam int unsigned CNTR_WIDTH_DEF       = 32;
  localparam int unsigned STATE_W              = 2;

  // Status codes as seen by software on sts_state.
  localparam logic [STATE_W-1:0] STATE_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] STATE_ARMED   = 2'd1;
  localparam logic [STATE_W-1:0] STATE_CAPTURE = 2'd2;
  localparam logic [STATE_W-1:0] STATE_DONE    = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = STATE_IDLE,
    ST_ARMED   = STATE_ARMED,
    ST_CAPTURE = STATE_CAPTURE,
    ST_DONE    = STATE_DONE
  } state_e;

  // Status code for a given FSM state.
  function automatic logic [STATE_W-1:0] state_code(input state_e s);
    return STATE_W'(s);
  endfunction

endpackage : axis_gpio_sampler_pkg

// File: rtl/axis_gpio_sampler_if.sv
// -----------------------------------------------------------------------------
// axis_gpio_sampler_if
// AXI4-Stream channel bundle used for both the GPIO sample input and the
// packetised burst output of axis_gpio_sampler.
//   tdata  : DATA_W-bit payload
//   tvalid : source has a beat
//   tready : sink accepts the beat
//   tlast  : final beat of a packet
// Modports: master = stream source, slave = stream sink.
// -----------------------------------------------------------------------------
interface axis_gpio_sampler_if
  import axis_gpio_sampler_pkg::*;
#(
  parameter int unsigned DATA_W = AXIS_TDATA_WIDTH_DEF
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface : axis_gpio_sampler_if

// File: rtl/axis_gpio_edge_detect.sv
// -----------------------------------------------------------------------------
// axis_gpio_edge_detect
// Keeps the previously accepted GPIO word and reports a masked rising edge
// on the current beat. Edges are suppressed until one beat has been seen
// since reset, so a line that is already high is not mistaken for an edge.
// Ports:
//   aclk, areset : clock, synchronous active-high reset
//   i_mask       : bits that participate in edge detection
//   i_data       : current GPIO word
//   i_accept     : current beat is accepted (updates history)
//   o_edge_c     : combinational masked rising-edge flag for i_data
// -----------------------------------------------------------------------------
module axis_gpio_edge_detect
  import axis_gpio_sampler_pkg::*;
#(
  parameter int unsigned DATA_W = AXIS_TDATA_WIDTH_DEF
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] i_mask,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_accept,
  output logic              o_edge_c
);

  logic [DATA_W-1:0] r_prev;
  logic              r_prev_ok;

  // History of the last accepted beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_prev    <= '0;
      r_prev_ok <= 1'b0;
    end else if (i_accept) begin
      r_prev    <= i_data;
      r_prev_ok <= 1'b1;
    end
  end

  assign o_edge_c = r_prev_ok && (|(i_mask & i_data & ~r_prev));

endmodule : axis_gpio_edge_detect

// File: rtl/axis_gpio_sampler.sv
// -----------------------------------------------------------------------------
// axis_gpio_sampler
// Capture sequencer between an always-valid GPIO sample stream and a DMA/FIFO
// writer. Arms on command, triggers on a masked rising edge or a software
// pulse, then emits cfg_count samples, one every cfg_decim+1 accepted input
// beats, as one AXI4-Stream packet with tlast on the final sample.
// Ports:
//   aclk, areset   : clock, synchronous active-high reset
//   cfg_mask       : edge-trigger bit mask (used live)
//   cfg_decim      : decimation, latched on arm
//   cfg_count      : samples per burst, latched on arm (0 = arm ignored)
//   arm, trg_soft  : single-cycle command pulses
//   s_axis         : GPIO input stream (slave)
//   m_axis         : sample output stream (master)
//   sts_state      : 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   sts_count      : samples loaded in the current/last burst
//   sts_overflow   : sticky, an input beat was refused
// -----------------------------------------------------------------------------
module axis_gpio_sampler
  import axis_gpio_sampler_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = AXIS_TDATA_WIDTH_DEF,
  parameter int unsigned CNTR_WIDTH       = CNTR_WIDTH_DEF
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_mask,
  input  logic [CNTR_WIDTH-1:0]       cfg_decim,
  input  logic [CNTR_WIDTH-1:0]       cfg_count,
  input  logic                        arm,
  input  logic                        trg_soft,
  axis_gpio_sampler_if.slave          s_axis,
  axis_gpio_sampler_if.master         m_axis,
  output logic [STATE_W-1:0]          sts_state,
  output logic [CNTR_WIDTH-1:0]       sts_count,
  output logic                        sts_overflow
);

  localparam int unsigned DW = AXIS_TDATA_WIDTH;
  localparam int unsigned CW = CNTR_WIDTH;

  state_e          r_state;
  state_e          w_state_nxt;

  logic [CW-1:0]   r_decim;
  logic [CW-1:0]   r_count_tgt;
  logic [CW-1:0]   r_decim_cnt;
  logic [CW-1:0]   r_sts_count;
  logic            r_overflow;
  logic            r_soft_pend;

  logic [DW-1:0]   r_tdata;
  logic            r_tvalid;
  logic            r_tlast;

  logic            w_tready;
  logic            w_accept;
  logic            w_refuse;
  logic            w_drain;
  logic            w_edge;
  logic            w_soft;
  logic            w_cnt_zero;
  logic [CW-1:0]   w_sts_inc;
  logic            w_arm_ok;
  logic            w_load;
  logic            w_load_last;
  logic            w_cap_dec;
  logic            w_unused_tlast;

  // The GPIO source never frames packets.
  assign w_unused_tlast = s_axis.tlast;

  axis_gpio_edge_detect #(
    .DATA_W (DW)
  ) u_edge (
    .aclk     (aclk),
    .areset   (areset),
    .i_mask   (cfg_mask),
    .i_data   (s_axis.tdata),
    .i_accept (w_accept),
    .o_edge_c (w_edge)
  );

  // Input is only refused when a sample is due but the output slot is stuck.
  assign w_cnt_zero = (r_decim_cnt == '0);
  assign w_tready   = !((r_state == ST_CAPTURE) && w_cnt_zero &&
                        r_tvalid && !m_axis.tready);
  assign w_accept   = s_axis.tvalid && w_tready;
  assign w_refuse   = s_axis.tvalid && !w_tready;
  assign w_drain    = r_tvalid && m_axis.tready;
  // A pulse in the trigger cycle itself counts as pending.
  assign w_soft     = r_soft_pend || trg_soft;
  assign w_sts_inc  = r_sts_count + CW'(1);

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_arm_ok    = 1'b0;
    w_load      = 1'b0;
    w_load_last = 1'b0;
    w_cap_dec   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (arm && (cfg_count != '0)) begin
          w_arm_ok    = 1'b1;
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_accept && (w_edge || w_soft)) begin
          w_load      = 1'b1;
          w_load_last = (r_count_tgt == CW'(1));
          w_state_nxt = w_load_last ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (w_accept) begin
          if (w_cnt_zero) begin
            w_load      = 1'b1;
            w_load_last = (w_sts_inc == r_count_tgt);
            if (w_load_last) begin
              w_state_nxt = ST_DONE;
            end
          end else begin
            w_cap_dec = 1'b1;
          end
        end
      end
      ST_DONE: begin
        // The output slot holds the tlast beat until it drains.
        if (w_drain) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Burst configuration, counters and status.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_decim     <= '0;
      r_count_tgt <= '0;
      r_decim_cnt <= '0;
      r_sts_count <= '0;
      r_overflow  <= 1'b0;
      r_soft_pend <= 1'b0;
    end else begin
      if (w_arm_ok) begin
        r_decim     <= cfg_decim;
        r_count_tgt <= cfg_count;
        r_sts_count <= '0;
      end

      // sts_count is 0 while armed, so the first load yields 1.
      if (w_load) begin
        r_sts_count <= w_sts_inc;
        r_decim_cnt <= r_decim;
      end else if (w_cap_dec) begin
        r_decim_cnt <= r_decim_cnt - CW'(1);
      end

      if (r_state == ST_ARMED) begin
        if (w_load) begin
          r_soft_pend <= 1'b0;
        end else if (trg_soft) begin
          r_soft_pend <= 1'b1;
        end
      end

      if (w_arm_ok) begin
        r_overflow <= 1'b0;
      end else if (w_refuse) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Single-stage output register; a load wins over a drain.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (w_load) begin
      r_tdata  <= s_axis.tdata;
      r_tvalid <= 1'b1;
      r_tlast  <= w_load_last;
    end else if (m_axis.tready) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

  assign s_axis.tready = w_tready;
  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;

  assign sts_state    = state_code(r_state);
  assign sts_count    = r_sts_count;
  assign sts_overflow = r_overflow;

endmodule : axis_gpio_sampler

// File: tb/tb_axis_gpio_sampler.sv
// -----------------------------------------------------------------------------
// tb_axis_gpio_sampler
// Scoreboard bench: a transaction-level model decides, from the stream rules,
// which input beats become samples and queues them; a monitor pops the queue
// on every output handshake.
// -----------------------------------------------------------------------------
module tb_axis_gpio_sampler;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] cfg_mask;
  logic [CW-1:0] cfg_decim;
  logic [CW-1:0] cfg_count;
  logic          arm;
  logic          trg_soft;
  logic [1:0]    sts_state;
  logic [CW-1:0] sts_count;
  logic          sts_overflow;

  axis_gpio_sampler_if #(.DATA_W(DW)) s_if ();
  axis_gpio_sampler_if #(.DATA_W(DW)) m_if ();

  axis_gpio_sampler #(
    .AXIS_TDATA_WIDTH (DW),
    .CNTR_WIDTH       (CW)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_mask     (cfg_mask),
    .cfg_decim    (cfg_decim),
    .cfg_count    (cfg_count),
    .arm          (arm),
    .trg_soft     (trg_soft),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .sts_state    (sts_state),
    .sts_count    (sts_count),
    .sts_overflow (sts_overflow)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] d;
    bit            last;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int prints   = 0;

  // Reference model: phase 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
  int            m_st      = 0;
  int unsigned   m_n       = 0;
  int unsigned   m_target  = 0;
  int unsigned   m_decim   = 0;
  int unsigned   m_since   = 0;
  logic [DW-1:0] m_prev    = '0;
  bit            m_prev_ok = 1'b0;
  bit            m_pend    = 1'b0;
  bit            m_full    = 1'b0;
  bit            m_ovf     = 1'b0;

  int unsigned   seq = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (prints < 40) begin
        prints++;
        $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
    end
  endtask

  // Model: compare status against the model, then advance it by one cycle.
  always @(negedge aclk) begin : model
    bit rdy, acc, drained, edge_c, fire, due;
    chk("sts_state",    64'(sts_state),    64'(m_st));
    chk("sts_count",    64'(sts_count),    64'(m_n));
    chk("sts_overflow", 64'(sts_overflow), 64'(m_ovf));
    chk("m_tvalid",     64'(m_if.tvalid),  64'(m_full));
    due = (m_st == 2) && (m_since == m_decim);
    rdy = !(due && m_full && !m_if.tready);
    chk("s_tready", 64'(s_if.tready), 64'(rdy));
    if (areset) begin
      m_st = 0; m_n = 0; m_ovf = 0; m_prev = '0; m_prev_ok = 0;
      m_pend = 0; m_full = 0; m_since = 0;
      exp_q.delete();
    end else begin
      acc     = s_if.tvalid && rdy;
      drained = m_full && m_if.tready;
      edge_c  = m_prev_ok && ((cfg_mask & s_if.tdata & ~m_prev) != '0);
      fire    = 0;
      case (m_st)
        0: if (arm && cfg_count != '0) begin
             m_decim = cfg_decim; m_target = cfg_count; m_n = 0; m_ovf = 0; m_st = 1;
           end
        1: if (acc && (edge_c || m_pend || trg_soft)) begin
             fire = 1; m_n = 1; m_since = 0; m_pend = 0;
             m_st = (m_target == 1) ? 3 : 2;
           end else if (trg_soft) begin
             m_pend = 1;
           end
        2: if (acc) begin
             if (m_since == m_decim) begin
               fire = 1; m_n++; m_since = 0;
               if (m_n == m_target) m_st = 3;
             end else begin
               m_since++;
             end
           end
        default: if (drained) m_st = 0;
      endcase
      if (fire) exp_q.push_back('{d: s_if.tdata, last: (m_n == m_target)});
      m_full = fire ? 1'b1 : (drained ? 1'b0 : m_full);
      if (s_if.tvalid && !rdy) m_ovf = 1;
      if (acc) begin
        m_prev = s_if.tdata; m_prev_ok = 1;
      end
    end
  end

  // Monitor: every output handshake must match the oldest expected sample.
  always @(negedge aclk) begin : monitor
    exp_t e;
    if (!areset && m_if.tvalid && m_if.tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=0x%0h required=none at %0t", m_if.tdata, $time);
      end else begin
        e = exp_q.pop_front();
        chk("m_tdata", 64'(m_if.tdata), 64'(e.d));
        chk("m_tlast", 64'(m_if.tlast), 64'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic step();
    s_if.tdata = DW'(seq);
    seq++;
    tick();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic pulse_soft();
    trg_soft = 1'b1;
    step();
    trg_soft = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (m_st != 0 && n < bound) begin
      step();
      n++;
    end
    if (m_st != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout_idle actual=phase%0d required=phase0 at %0t", m_st, $time);
      areset = 1'b1;
      tick();
      areset = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    areset     = 1'b1;
    arm        = 1'b0;
    trg_soft   = 1'b0;
    cfg_mask   = '0;
    cfg_decim  = '0;
    cfg_count  = '0;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b1;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) tick();
    chk("reset_tdata", 64'(m_if.tdata), 64'd0);
    chk("reset_tlast", 64'(m_if.tlast), 64'd0);
    areset = 1'b0;

    // Masked 0->1 edge on bit0 at beat 10, four undecimated samples.
    cfg_mask = 32'h1; cfg_decim = 0; cfg_count = 4;
    s_if.tdata = '0;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_if.tdata = DW'(i << 4) | ((i >= 10) ? 32'h1 : 32'h0);
      tick();
    end
    chk("edge_burst_idle", 64'(sts_state), 64'd0);
    chk("edge_burst_count", 64'(sts_count), 64'd4);

    // Soft trigger, decimation 2.
    cfg_mask = '0; cfg_decim = 2; cfg_count = 3;
    pulse_arm();
    step(); step();
    pulse_soft();
    wait_idle(100);
    chk("soft_burst_count", 64'(sts_count), 64'd3);

    // Downstream stall mid-burst.
    cfg_decim = 0; cfg_count = 8;
    pulse_arm();
    pulse_soft();
    step(); step();
    m_if.tready = 1'b0;
    step();
    chk("bp_tready_low", 64'(s_if.tready), 64'd0);
    repeat (4) step();
    chk("bp_overflow", 64'(sts_overflow), 64'd1);
    m_if.tready = 1'b1;
    wait_idle(100);
    chk("bp_count", 64'(sts_count), 64'd8);

    // Line already high on the first beat after reset must not trigger.
    areset = 1'b1; s_if.tvalid = 1'b0; s_if.tdata = 32'h1;
    tick();
    areset = 1'b0;
    cfg_mask = 32'h1; cfg_decim = 0; cfg_count = 2;
    arm = 1'b1; tick(); arm = 1'b0;
    s_if.tvalid = 1'b1;
    repeat (5) tick();
    chk("no_early_trigger", 64'(sts_state), 64'd1);
    s_if.tdata = 32'h0; tick();
    s_if.tdata = 32'h3; tick();
    s_if.tdata = 32'h5; tick();
    chk("late_edge_done", 64'(sts_state), 64'd3);
    wait_idle(50);

    // Ignored arms: zero count, and while capturing.
    cfg_mask = '0; cfg_count = 0;
    pulse_arm();
    chk("arm_cnt0_ignored", 64'(sts_state), 64'd0);
    cfg_count = 6; cfg_decim = 1;
    pulse_arm();
    pulse_soft();
    step(); step();
    cfg_count = 2; cfg_decim = 0;
    pulse_arm();
    chk("arm_in_capture", 64'(sts_state), 64'd2);
    wait_idle(100);
    chk("arm_in_capture_cnt", 64'(sts_count), 64'd6);

    // Reset while capturing with overflow set.
    cfg_count = 10; cfg_decim = 0;
    pulse_arm();
    pulse_soft();
    step();
    m_if.tready = 1'b0;
    repeat (3) step();
    areset = 1'b1;
    tick();
    chk("rst_mid_tvalid",   64'(m_if.tvalid),  64'd0);
    chk("rst_mid_state",    64'(sts_state),    64'd0);
    chk("rst_mid_count",    64'(sts_count),    64'd0);
    chk("rst_mid_overflow", 64'(sts_overflow), 64'd0);
    areset = 1'b0;
    m_if.tready = 1'b1;
    step();

    // Randomised bursts with random valid, ready, triggers and config churn.
    for (int b = 0; b < 30; b++) begin
      int n;
      cfg_decim = CW'($urandom_range(0, 3));
      cfg_count = CW'($urandom_range(1, 6));
      cfg_mask  = $urandom;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      n = 0;
      while (m_st != 0 && n < 600) begin
        s_if.tvalid = ($urandom_range(0, 9) != 0);
        s_if.tdata  = $urandom;
        m_if.tready = ($urandom_range(0, 9) < 7);
        trg_soft    = ($urandom_range(0, 15) == 0);
        arm         = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 19) == 0) begin
          cfg_decim = CW'($urandom_range(0, 3));
          cfg_count = CW'($urandom_range(0, 6));
        end
        tick();
        n++;
      end
      arm = 1'b0; trg_soft = 1'b0;
      s_if.tvalid = 1'b1; m_if.tready = 1'b1;
      if (m_st != 0) begin
        checks++;
        failures++;
        $display("FAIL random_burst_timeout actual=phase%0d required=phase0 at %0t", m_st, $time);
        areset = 1'b1;
        tick();
        areset = 1'b0;
      end
      tick();
    end

    repeat (4) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_axis_gpio_sampler
